// File: rtl/ring_osc_pkg.sv
// Shared types, constants and width helper for the ring oscillator meter.
package ring_osc_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_GATE   = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  // Bits needed to count 0..limit-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/ring_osc_meter_sync.sv
// Synchroniser for an asynchronous tap plus a one-cycle rising-edge pulse.
module sync_edge_detect
  import ring_osc_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the synchroniser and keep the last synced value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_osc_meter.sv
// Ring oscillator sequencer and gated edge counter with dead-oscillator detection.
module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned GATE_CYCLES   = 65536,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned DEAD_CYCLES   = 4096,
  parameter bit          AUTO_OFF      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             osc_tap,
  output logic             osc_enable,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             dead
);

  localparam int unsigned TMR_LIMIT = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W     = cnt_width(TMR_LIMIT);
  localparam int unsigned DEAD_W    = cnt_width(DEAD_CYCLES);

  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST   = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  state_t             state_q,    state_d;
  logic [TMR_W-1:0]   tmr_q,      tmr_d;
  logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               osc_enable_d;
  logic               busy_d;
  logic [CNT_W-1:0]   result_d;
  logic               result_valid_d;
  logic               dead_d;

  logic               tap_pulse_c;
  logic [CNT_W-1:0]   edge_next_c;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_tap_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (osc_tap),
    .pulse_c  (tap_pulse_c)
  );

  // Saturating edge count including this cycle's pulse.
  assign edge_next_c = (tap_pulse_c && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + CNT_W'(1)
                                                                 : edge_cnt_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      dead_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      osc_enable   <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      dead         <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      dead_cnt_q   <= dead_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      osc_enable   <= osc_enable_d;
      busy         <= busy_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      dead         <= dead_d;
    end
  end

  // Next-state and next-output logic; stop overrides every state.
  always_comb begin
    state_d        = state_q;
    tmr_d          = tmr_q;
    dead_cnt_d     = dead_cnt_q;
    edge_cnt_d     = edge_cnt_q;
    osc_enable_d   = osc_enable;
    busy_d         = busy;
    result_d       = result;
    result_valid_d = result_valid;
    dead_d         = dead;

    if (stop) begin
      state_d        = ST_IDLE;
      osc_enable_d   = 1'b0;
      busy_d         = 1'b0;
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d      = ST_SETTLE;
            tmr_d        = '0;
            osc_enable_d = 1'b1;
            busy_d       = 1'b1;
            dead_d       = 1'b0;
          end
        end

        ST_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            state_d    = ST_GATE;
            tmr_d      = '0;
            edge_cnt_d = '0;
            dead_cnt_d = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end

        ST_GATE: begin
          edge_cnt_d = edge_next_c;
          // Dead timeout wins if it lands on the final gate cycle.
          if (!tap_pulse_c && (dead_cnt_q == DEAD_LAST)) begin
            state_d        = ST_HOLD;
            dead_d         = 1'b1;
            result_d       = '0;
            result_valid_d = 1'b1;
          end else if (tmr_q == GATE_LAST) begin
            state_d        = ST_HOLD;
            result_d       = edge_next_c;
            result_valid_d = 1'b1;
          end else begin
            tmr_d      = tmr_q + TMR_W'(1);
            dead_cnt_d = tap_pulse_c ? '0 : dead_cnt_q + DEAD_W'(1);
          end
        end

        ST_HOLD: begin
          if (result_ready) begin
            state_d        = ST_IDLE;
            busy_d         = 1'b0;
            result_valid_d = 1'b0;
            if (AUTO_OFF) begin
              osc_enable_d = 1'b0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench: three meter instances (nominal, narrow counter, AUTO_OFF=0).
module tb_ring_osc_meter;

  logic clk;
  logic rst;

  logic        start_a, stop_a, tap_a, ready_a;
  logic        en_a, busy_a, rv_a, dead_a;
  logic [19:0] res_a;

  logic        start_s, stop_s, tap_s, ready_s;
  logic        en_s, busy_s, rv_s, dead_s;
  logic [3:0]  res_s;

  logic        start_n, stop_n, tap_n, ready_n;
  logic        en_n, busy_n, rv_n, dead_n;
  logic [19:0] res_n;

  int per_a;
  int per_s;
  int per_n;

  int n_checks;
  int n_fail;

  logic seen_valid;

  ring_osc_meter #(
    .SETTLE_CYCLES (16), .GATE_CYCLES (1000), .CNT_W (20), .DEAD_CYCLES (64), .AUTO_OFF (1'b1)
  ) u_a (
    .clk (clk), .rst (rst), .start (start_a), .stop (stop_a), .osc_tap (tap_a),
    .osc_enable (en_a), .busy (busy_a), .result (res_a), .result_valid (rv_a),
    .result_ready (ready_a), .dead (dead_a)
  );

  ring_osc_meter #(
    .SETTLE_CYCLES (16), .GATE_CYCLES (200), .CNT_W (4), .DEAD_CYCLES (64), .AUTO_OFF (1'b1)
  ) u_s (
    .clk (clk), .rst (rst), .start (start_s), .stop (stop_s), .osc_tap (tap_s),
    .osc_enable (en_s), .busy (busy_s), .result (res_s), .result_valid (rv_s),
    .result_ready (ready_s), .dead (dead_s)
  );

  ring_osc_meter #(
    .SETTLE_CYCLES (16), .GATE_CYCLES (1000), .CNT_W (20), .DEAD_CYCLES (64), .AUTO_OFF (1'b0)
  ) u_n (
    .clk (clk), .rst (rst), .start (start_n), .stop (stop_n), .osc_tap (tap_n),
    .osc_enable (en_n), .busy (busy_n), .result (res_n), .result_valid (rv_n),
    .result_ready (ready_n), .dead (dead_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tap generators: period in clk cycles, 0 holds the tap low; edges sit off the clk edges.
  initial begin
    tap_a = 1'b0;
    #2;
    forever begin
      if (per_a == 0) begin tap_a = 1'b0; #10; end
      else begin tap_a = 1'b1; #(per_a * 5); tap_a = 1'b0; #(per_a * 5); end
    end
  end

  initial begin
    tap_s = 1'b0;
    #2;
    forever begin
      if (per_s == 0) begin tap_s = 1'b0; #10; end
      else begin tap_s = 1'b1; #(per_s * 5); tap_s = 1'b0; #(per_s * 5); end
    end
  end

  initial begin
    tap_n = 1'b0;
    #2;
    forever begin
      if (per_n == 0) begin tap_n = 1'b0; #10; end
      else begin tap_n = 1'b1; #(per_n * 5); tap_n = 1'b0; #(per_n * 5); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    per_a = 10; per_s = 6; per_n = 10;
    rst = 1'b1;
    start_a = 0; stop_a = 0; ready_a = 0;
    start_s = 0; stop_s = 0; ready_s = 0;
    start_n = 0; stop_n = 0; ready_n = 0;

    // Reset values
    ticks(3);
    chk("rst_en",    32'(en_a),   0);
    chk("rst_busy",  32'(busy_a), 0);
    chk("rst_res",   32'(res_a),  0);
    chk("rst_valid", 32'(rv_a),   0);
    chk("rst_dead",  32'(dead_a), 0);
    rst = 1'b0;
    ticks(5);

    // Nominal measurement: period 10 over 1000 cycles
    start_a = 1; tick(); start_a = 0;
    chk("start_busy", 32'(busy_a), 1);
    chk("start_en",   32'(en_a),   1);
    ticks(1015);
    chk("nom_valid_early", 32'(rv_a), 0);
    tick();
    chk("nom_valid",  32'(rv_a),  1);
    chk("nom_result", 32'(res_a), 100);
    chk("nom_dead",   32'(dead_a), 0);
    ready_a = 1; tick(); ready_a = 0;
    chk("hs_en",    32'(en_a),   0);
    chk("hs_busy",  32'(busy_a), 0);
    chk("hs_valid", 32'(rv_a),   0);

    // Dead oscillator: timeout exactly 64 cycles into the gate
    per_a = 0;
    ticks(20);
    start_a = 1; tick(); start_a = 0;
    ticks(79);
    chk("dead_valid_early", 32'(rv_a),   0);
    chk("dead_flag_early",  32'(dead_a), 0);
    tick();
    chk("dead_flag",   32'(dead_a), 1);
    chk("dead_valid",  32'(rv_a),   1);
    chk("dead_result", 32'(res_a),  0);

    // Consumer stalls 50 cycles; a start during HOLD must be ignored
    for (int i = 0; i < 50; i++) begin
      start_a = (i == 25);
      tick();
      chk("hold_valid",  32'(rv_a),  1);
      chk("hold_result", 32'(res_a), 0);
    end
    start_a = 0;
    ready_a = 1; tick(); ready_a = 0;
    chk("dead_hs_busy",  32'(busy_a), 0);
    chk("dead_hs_valid", 32'(rv_a),   0);
    chk("dead_sticky",   32'(dead_a), 1);
    tick();
    chk("hold_start_ignored", 32'(busy_a), 0);

    // Saturating 4-bit counter
    ticks(5);
    start_s = 1; tick(); start_s = 0;
    ticks(215);
    chk("sat_valid_early", 32'(rv_s), 0);
    tick();
    chk("sat_valid",  32'(rv_s),  1);
    chk("sat_result", 32'(res_s), 15);
    ready_s = 1; tick(); ready_s = 0;
    chk("sat_hs_en", 32'(en_s), 0);

    // Stop mid-gate, then a clean measurement
    per_a = 10;
    ticks(10);
    start_a = 1; tick(); start_a = 0;
    chk("restart_dead_clr", 32'(dead_a), 0);
    ticks(500);
    stop_a = 1; tick(); stop_a = 0;
    chk("stop_en",    32'(en_a),   0);
    chk("stop_busy",  32'(busy_a), 0);
    chk("stop_valid", 32'(rv_a),   0);
    seen_valid = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      seen_valid = seen_valid | rv_a;
    end
    chk("stop_no_valid", 32'(seen_valid), 0);
    start_a = 1; tick(); start_a = 0;
    ticks(1016);
    chk("post_stop_valid",  32'(rv_a),  1);
    chk("post_stop_result", 32'(res_a), 100);

    // Reset in HOLD alongside result_ready
    rst = 1; ready_a = 1; tick(); rst = 0; ready_a = 0;
    chk("hold_rst_en",    32'(en_a),   0);
    chk("hold_rst_busy",  32'(busy_a), 0);
    chk("hold_rst_res",   32'(res_a),  0);
    chk("hold_rst_valid", 32'(rv_a),   0);
    chk("hold_rst_dead",  32'(dead_a), 0);

    // AUTO_OFF=0 keeps the oscillator running until stop
    ticks(3);
    start_n = 1; tick(); start_n = 0;
    ticks(1016);
    chk("noff_valid",  32'(rv_n),  1);
    chk("noff_result", 32'(res_n), 100);
    ready_n = 1; tick(); ready_n = 0;
    chk("noff_hs_busy", 32'(busy_n), 0);
    chk("noff_hs_en",   32'(en_n),   1);
    ticks(10);
    chk("noff_idle_en", 32'(en_n), 1);
    stop_n = 1; tick(); stop_n = 0;
    chk("noff_stop_en", 32'(en_n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
